// File: rtl/sound_pkg.sv
// Shared types and tone constants for the sound-effect player.
package sound_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        MOVE = 2'd1,
        BAD  = 2'd2,
        GOOD = 2'd3
    } evt_e;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        HOLDOFF = 2'd2
    } state_e;

    localparam int unsigned HP_GOOD = 107;
    localparam int unsigned HP_BAD  = 151;
    localparam int unsigned HP_MOVE = 179;

    // Priority encode a request vector: good > bad > move.
    function automatic evt_e evt_from_req(input logic [2:0] req);
        evt_e e;
        if (req[2])      e = GOOD;
        else if (req[1]) e = BAD;
        else if (req[0]) e = MOVE;
        else             e = NONE;
        return e;
    endfunction

    // Nominal half-period of each event tone, in clk cycles minus one.
    function automatic int unsigned hp_of(input evt_e e);
        int unsigned hp;
        case (e)
            GOOD:    hp = HP_GOOD;
            BAD:     hp = HP_BAD;
            MOVE:    hp = HP_MOVE;
            default: hp = 0;
        endcase
        return hp;
    endfunction

endpackage

// File: rtl/tone_divider.sv
// Half-period counter producing the tone tick pulse and square wave.
module tone_divider #(
    parameter int unsigned DIV_W = 8
) (
    input  logic             clk,
    input  logic             nRst,
    input  logic             load_i,
    input  logic [DIV_W-1:0] period_i,
    input  logic             clear_i,
    output logic             tone_tick_o,
    output logic             tone_out_o
);

    logic [DIV_W-1:0] count_q;
    logic             tick_q;
    logic             out_q;

    // Count 0..period; wrap with a one-cycle tick and a wave toggle.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            out_q   <= 1'b0;
        end else if (clear_i || load_i) begin
            count_q <= '0;
            tick_q  <= 1'b0;
            out_q   <= 1'b0;
        end else if (count_q == period_i) begin
            count_q <= '0;
            tick_q  <= 1'b1;
            out_q   <= ~out_q;
        end else begin
            count_q <= count_q + DIV_W'(1);
            tick_q  <= 1'b0;
        end
    end

    assign tone_tick_o = tick_q;
    assign tone_out_o  = out_q;

endmodule

// File: rtl/sfx_player.sv
// Event-driven sound-effect player: IDLE -> PLAY -> HOLDOFF.
// Optional BAD-tone pitch sweep enabled by defining SFX_SWEEP_EN.
module sfx_player
    import sound_pkg::*;
#(
    parameter int unsigned DIV_W      = 8,
    parameter int unsigned DUR_W      = 24,
    parameter int unsigned DURATION   = 10000000,
    parameter int unsigned GAP        = 1000,
    parameter int unsigned SWEEP_STEP = 64
) (
    input  logic       clk,
    input  logic       nRst,
    input  logic       en,
    input  logic [2:0] evt_req,
    output logic       tone_tick,
    output logic       tone_out,
    output logic       busy,
    output logic [1:0] cur_evt
);

    // Constants wider than the divider saturate to all-ones.
    function automatic logic [DIV_W-1:0] sat_hp(input int unsigned v);
        logic [DIV_W-1:0] r;
        if (64'(v) > ((64'd1 << DIV_W) - 64'd1)) r = '1;
        else                                    r = DIV_W'(v);
        return r;
    endfunction

    state_e           state_q, state_d;
    evt_e             cur_evt_q, cur_evt_d;
    evt_e             req_evt;
    logic             req_any;
    logic             preempt_c;
    logic             dur_done, gap_done;
    logic             busy_q, busy_d;
    logic [DIV_W-1:0] period_q, period_d;
    logic [DUR_W-1:0] dur_q, dur_d;
    logic [DUR_W-1:0] gap_q, gap_d;
    logic             load_c, clear_c;

`ifdef SFX_SWEEP_EN
    localparam int unsigned SwcW = (SWEEP_STEP > 1) ? $clog2(SWEEP_STEP) : 1;
    logic [SwcW-1:0] swcnt_q, swcnt_d;
`else
    if (SWEEP_STEP == 0) begin : g_no_sweep
    end
`endif

    assign req_evt   = evt_from_req(evt_req);
    assign req_any   = |evt_req;
    assign preempt_c = (state_q == PLAY) && en && req_any && (req_evt > cur_evt_q);
    assign dur_done  = (dur_q == DUR_W'(DURATION - 1));
    assign gap_done  = (gap_q == DUR_W'(GAP - 1));

    // State register.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; a preempt outranks duration expiry.
    always_comb begin
        state_d = state_q;
        if (!en) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (req_any) state_d = PLAY;
                PLAY:    if (!preempt_c && dur_done) state_d = HOLDOFF;
                HOLDOFF: if (gap_done) state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
    end

    // Output/datapath next values, keyed on the upcoming state.
    always_comb begin
        load_c    = 1'b0;
        clear_c   = (state_d != PLAY);
        busy_d    = (state_d != IDLE);
        cur_evt_d = NONE;
        period_d  = period_q;
        dur_d     = '0;
        gap_d     = '0;
`ifdef SFX_SWEEP_EN
        swcnt_d   = '0;
`endif
        case (state_d)
            PLAY: begin
                if (state_q != PLAY || preempt_c) begin
                    load_c    = 1'b1;
                    cur_evt_d = req_evt;
                    period_d  = sat_hp(hp_of(req_evt));
                end else begin
                    cur_evt_d = cur_evt_q;
                    dur_d     = dur_q + DUR_W'(1);
`ifdef SFX_SWEEP_EN
                    swcnt_d = swcnt_q;
                    if (cur_evt_q == BAD && tone_tick) begin
                        if (swcnt_q == SwcW'(SWEEP_STEP - 1)) begin
                            swcnt_d = '0;
                            if (period_q != '1) period_d = period_q + DIV_W'(1);
                        end else begin
                            swcnt_d = swcnt_q + SwcW'(1);
                        end
                    end
`endif
                end
            end
            HOLDOFF: gap_d = (state_q == HOLDOFF) ? gap_q + DUR_W'(1) : '0;
            default: ;
        endcase
    end

    // Datapath and registered status outputs.
    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            cur_evt_q <= NONE;
            busy_q    <= 1'b0;
            period_q  <= '0;
            dur_q     <= '0;
            gap_q     <= '0;
`ifdef SFX_SWEEP_EN
            swcnt_q   <= '0;
`endif
        end else begin
            cur_evt_q <= cur_evt_d;
            busy_q    <= busy_d;
            period_q  <= period_d;
            dur_q     <= dur_d;
            gap_q     <= gap_d;
`ifdef SFX_SWEEP_EN
            swcnt_q   <= swcnt_d;
`endif
        end
    end

    tone_divider #(.DIV_W(DIV_W)) u_div (
        .clk         (clk),
        .nRst        (nRst),
        .load_i      (load_c),
        .period_i    (period_q),
        .clear_i     (clear_c),
        .tone_tick_o (tone_tick),
        .tone_out_o  (tone_out)
    );

    assign busy    = busy_q;
    assign cur_evt = cur_evt_q;

endmodule

// File: tb/tb_sfx_player.sv
// Directed bench for sfx_player; second instance uses DIV_W=7 to exercise saturation.
module tb_sfx_player;
    import sound_pkg::*;

    localparam int unsigned DUR = 2000;
    localparam int unsigned GP  = 20;

    logic       clk = 1'b0;
    logic       nRst;
    logic       en;
    logic [2:0] evt_req;
    logic       tone_tick, tone_out, busy;
    logic [1:0] cur_evt;
    logic       tick7, out7, busy7;
    logic [1:0] evt7;

    int checks = 0;
    int errors = 0;
    int c, n, elapsed;

    always #5 clk = ~clk;

    sfx_player #(.DIV_W(8), .DUR_W(24), .DURATION(DUR), .GAP(GP), .SWEEP_STEP(4)) u_dut (
        .clk(clk), .nRst(nRst), .en(en), .evt_req(evt_req),
        .tone_tick(tone_tick), .tone_out(tone_out), .busy(busy), .cur_evt(cur_evt)
    );

    sfx_player #(.DIV_W(7), .DUR_W(24), .DURATION(DUR), .GAP(GP), .SWEEP_STEP(4)) u_dut7 (
        .clk(clk), .nRst(nRst), .en(en), .evt_req(evt_req),
        .tone_tick(tick7), .tone_out(out7), .busy(busy7), .cur_evt(evt7)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle request; returns at the negedge after it was sampled.
    task automatic pulse_req(input logic [2:0] v);
        evt_req = v;
        @(negedge clk);
        evt_req = 3'b000;
    endtask

    // Cycles until the next tick of the selected instance (bounded).
    task automatic wait_tick(input bit sel7, output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
        end while (!(sel7 ? tick7 : tone_tick) && cnt < 400);
    endtask

    task automatic count_ticks(input int cycles, output int ticks);
        ticks = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (tone_tick) ticks++;
        end
    endtask

    function automatic int exp_bad_sp(input int k);
`ifdef SFX_SWEEP_EN
        return (k <= 4) ? 152 : ((k <= 8) ? 153 : 154);
`else
        return (k > 0) ? 152 : 0;
`endif
    endfunction

    initial begin
        nRst = 1'b0; en = 1'b0; evt_req = 3'b000;
        repeat (3) @(negedge clk);
        chk("rst_tick", tone_tick, 0);
        chk("rst_out", tone_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_evt", cur_evt, NONE);
        nRst = 1'b1; en = 1'b1;
        @(negedge clk);
        chk("idle_busy", busy, 0);

        // Good tone: half-period 107 -> tick every 108 cycles.
        pulse_req(3'b100);
        chk("good_busy", busy, 1);
        chk("good_evt", cur_evt, GOOD);
        wait_tick(1'b0, c);
        chk("good_first", c, 108);
        chk("good_out_hi", tone_out, 1);
        wait_tick(1'b0, c);
        chk("good_sp", c, 108);
        chk("good_out_lo", tone_out, 0);

        // Lower-priority move during good is ignored.
        pulse_req(3'b001);
        wait_tick(1'b0, c);
        chk("ignore_sp", c + 1, 108);
        chk("ignore_evt", cur_evt, GOOD);
        chk("ignore_out", tone_out, 1);

        // Mute mid-play.
        en = 1'b0;
        @(negedge clk);
        chk("mute_busy", busy, 0);
        chk("mute_out", tone_out, 0);
        chk("mute_evt", cur_evt, NONE);
        pulse_req(3'b100);
        chk("mute_req_busy", busy, 0);
        count_ticks(200, n);
        chk("mute_ticks", n, 0);
        en = 1'b1;

        // Move tone, then preempted by bad.
        pulse_req(3'b001);
        chk("move_evt", cur_evt, MOVE);
        chk("sat7_busy", busy7, 1);
        wait_tick(1'b0, c);
        chk("move_first", c, 180);
        chk("move_out", tone_out, 1);
        pulse_req(3'b010);
        chk("pre_evt", cur_evt, BAD);
        chk("pre_out", tone_out, 0);
        elapsed = 0;
        for (int k = 1; k <= 9; k++) begin
            wait_tick(1'b0, c);
            chk($sformatf("bad_sp%0d", k), c, exp_bad_sp(k));
            elapsed += c;
        end
        while (elapsed < 1999) begin
            @(negedge clk);
            elapsed++;
        end
        chk("dur_last_evt", cur_evt, BAD);
        @(negedge clk);
        elapsed++;
        chk("hold_busy", busy, 1);
        chk("hold_out", tone_out, 0);
        chk("hold_tick", tone_tick, 0);
        chk("hold_evt", cur_evt, NONE);
        pulse_req(3'b100);
        elapsed++;
        chk("hold_req_evt", cur_evt, NONE);
        n = 0;
        while (busy && elapsed < 3000) begin
            @(negedge clk);
            elapsed++;
            if (tone_tick) n++;
        end
        chk("idle_at", elapsed, DUR + GP);
        chk("hold_ticks", n, 0);
        @(negedge clk);
        chk("post_idle_busy", busy, 0);

        // Reset pulse mid-play.
        pulse_req(3'b001);
        wait_tick(1'b0, c);
        chk("rmove_first", c, 180);
        chk("rmove_out", tone_out, 1);
        nRst = 1'b0;
        #1;
        chk("arst_busy", busy, 0);
        chk("arst_out", tone_out, 0);
        chk("arst_evt", cur_evt, NONE);
        @(negedge clk);
        nRst = 1'b1;
        @(negedge clk);
        chk("rel_tick", tone_tick, 0);
        chk("rel_busy", busy, 0);
        count_ticks(200, n);
        chk("rel_ticks", n, 0);

        // DIV_W=7: move constant 179 saturates to 127 -> 128-cycle spacing.
        pulse_req(3'b001);
        chk("sat7_evt", evt7, MOVE);
        wait_tick(1'b1, c);
        chk("sat7_first", c, 128);
        chk("sat7_out", out7, 1);
        wait_tick(1'b1, c);
        chk("sat7_sp", c, 128);

        en = 1'b0;
        @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
